// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the EX-stage multiply/divide unit:
// datapath width, MULT/DIV opcode encodings and controller states.
package mips_pkg;

    localparam int NB_DATA = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_RUN  = 2'b01,
        MDU_FIX  = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit holding the HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, sign fixed up in a final cycle.
module mult_div_unit #(
    parameter int NB_DATA = 32,
    parameter int NB_OP   = 2,
    parameter int NB_CNT  = 5
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [NB_OP-1:0]   i_op,
    input  logic [NB_DATA-1:0] i_rs,
    input  logic [NB_DATA-1:0] i_rt,
    input  logic               i_wr_hi,
    input  logic               i_wr_lo,
    input  logic [NB_DATA-1:0] i_wr_data,
    input  logic               i_flush,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_div_by_zero,
    output logic [NB_DATA-1:0] o_hi,
    output logic [NB_DATA-1:0] o_lo
);
    import mips_pkg::*;

    localparam int NW = 2 * NB_DATA;

    function automatic logic [NB_DATA-1:0] magnitude(input logic signed [NB_DATA-1:0] x);
        return x[NB_DATA-1] ? NB_DATA'(-x) : NB_DATA'(x);
    endfunction

    function automatic logic [NB_DATA-1:0] cond_neg(input logic [NB_DATA-1:0] x, input logic neg);
        return neg ? NB_DATA'(-x) : x;
    endfunction

    mdu_state_e          state_q;
    logic [NB_CNT-1:0]   cnt_q;
    logic [NW-1:0]       acc_q;
    logic [NB_DATA-1:0]  opnd_q;
    logic [NB_DATA-1:0]  rs_q;
    logic                is_div_q;
    logic                neg_res_q;
    logic                neg_rem_q;
    logic                dz_q;
    logic [NB_DATA-1:0]  hi_q;
    logic [NB_DATA-1:0]  lo_q;
    logic                busy_q;
    logic                done_q;
    logic                dbz_q;

    logic                signed_op;
    logic                div_op;
    logic [NB_DATA-1:0]  rs_mag;
    logic [NB_DATA-1:0]  rt_mag;
    logic [NB_DATA:0]    mul_sum;
    logic [NB_DATA+1:0]  div_diff;
    logic [NW-1:0]       acc_step;
    logic [NW-1:0]       prod_fix;

    always_comb begin
        signed_op = ~i_op[0];
        div_op    = i_op[1];
        rs_mag    = signed_op ? magnitude(i_rs) : i_rs;
        rt_mag    = signed_op ? magnitude(i_rt) : i_rt;

        // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}
        mul_sum  = {1'b0, acc_q[NW-1:NB_DATA]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_diff = {1'b0, acc_q[NW-1:NB_DATA-1]} - {2'b00, opnd_q};
        if (is_div_q) begin
            acc_step = div_diff[NB_DATA+1] ? {acc_q[NW-2:0], 1'b0}
                                           : {div_diff[NB_DATA-1:0], acc_q[NB_DATA-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc_q[NB_DATA-1:1]};
        end
        prod_fix = neg_res_q ? NW'(-acc_q) : acc_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= MDU_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            rs_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            if (!busy_q) begin
                if (i_wr_hi) hi_q <= i_wr_data;
                if (i_wr_lo) lo_q <= i_wr_data;
            end
            case (state_q)
                MDU_IDLE: begin
                    if (i_start && !i_flush) begin
                        state_q   <= MDU_RUN;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        is_div_q  <= div_op;
                        neg_res_q <= signed_op & (i_rs[NB_DATA-1] ^ i_rt[NB_DATA-1]);
                        neg_rem_q <= signed_op & i_rs[NB_DATA-1];
                        dz_q      <= div_op & (i_rt == '0);
                        rs_q      <= i_rs;
                        opnd_q    <= div_op ? rt_mag : rs_mag;
                        acc_q     <= {{NB_DATA{1'b0}}, (div_op ? rs_mag : rt_mag)};
                    end
                end
                MDU_RUN: begin
                    if (i_flush) begin
                        state_q <= MDU_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= acc_step;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == NB_CNT'(NB_DATA - 1)) state_q <= MDU_FIX;
                    end
                end
                MDU_FIX: begin
                    state_q <= MDU_IDLE;
                    busy_q  <= 1'b0;
                    if (!i_flush) begin
                        done_q <= 1'b1;
                        dbz_q  <= dz_q;
                        if (!is_div_q) begin
                            hi_q <= prod_fix[NW-1:NB_DATA];
                            lo_q <= prod_fix[NB_DATA-1:0];
                        end else if (dz_q) begin
                            hi_q <= rs_q;
                            lo_q <= '1;
                        end else begin
                            hi_q <= cond_neg(acc_q[NW-1:NB_DATA], neg_rem_q);
                            lo_q <= cond_neg(acc_q[NB_DATA-1:0], neg_res_q);
                        end
                    end
                end
                default: begin
                    state_q <= MDU_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_div_by_zero = dbz_q;
    assign o_hi          = hi_q;
    assign o_lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs, rt;
    logic        wr_hi, wr_lo;
    logic [31:0] wr_data;
    logic        flush;
    logic        busy, done, dbz;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_errors = 0;

    mult_div_unit dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op),
        .i_rs(rs), .i_rt(rt), .i_wr_hi(wr_hi), .i_wr_lo(wr_lo),
        .i_wr_data(wr_data), .i_flush(flush), .o_busy(busy), .o_done(done),
        .o_div_by_zero(dbz), .o_hi(hi), .o_lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns {div_by_zero, HI, LO} from plain integer arithmetic.
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin p = 64'(sa * sb); return {1'b0, p}; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; return {1'b0, p}; end
            default: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                if (o == 2'b10) begin q = sa / sb; r = sa % sb; end
                else begin q = longint'({32'b0, a}) / longint'({32'b0, b});
                           r = longint'({32'b0, a}) % longint'({32'b0, b}); end
                return {1'b0, r[31:0], q[31:0]};
            end
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [64:0] exp;
        int busy_cyc, done_cyc;
        logic dz_seen;
        exp = model(o, a, b);
        @(negedge clk);
        start = 1'b1; op = o; rs = a; rt = b;
        @(negedge clk);
        start = 1'b0;
        busy_cyc = 0; done_cyc = 0; dz_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (busy) busy_cyc++;
            if (done) begin done_cyc++; dz_seen = dbz; end
            @(negedge clk);
        end
        check({tag, " hi"}, 64'(hi), 64'(exp[63:32]));
        check({tag, " lo"}, 64'(lo), 64'(exp[31:0]));
        check({tag, " busy_cycles"}, 64'(busy_cyc), 64'd33);
        check({tag, " done_pulses"}, 64'(done_cyc), 64'd1);
        check({tag, " div_by_zero"}, 64'(dz_seen), 64'(exp[64]));
    endtask

    initial begin
        int cyc, done_cnt;
        logic [31:0] a, b;
        logic [1:0]  o;

        rst_n = 1'b0; start = 1'b0; op = '0; rs = '0; rt = '0;
        wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0; flush = 1'b0;
        repeat (2) @(negedge clk);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("mult_neg", 2'b00, 32'hFFFF_FFFE, 32'h0000_0003);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_neg7", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
        run_op("divu_7_2", 2'b11, 32'd7, 32'd2);
        run_op("divu_by0", 2'b11, 32'd5, 32'd0);
        run_op("div_by0", 2'b10, 32'h8765_4321, 32'd0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_negrem", 2'b10, 32'd7, 32'hFFFF_FFFE);

        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = -($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            run_op($sformatf("rand%0d", i), o, a, b);
        end

        // MTHI in IDLE, then a start/MTLO attempt while busy must be ignored
        @(negedge clk);
        wr_hi = 1'b1; wr_data = 32'h1234_5678;
        @(negedge clk);
        wr_hi = 1'b0;
        check("mthi", 64'(hi), 64'h1234_5678);
        start = 1'b1; op = 2'b01; rs = 32'd3; rt = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1; op = 2'b01; rs = 32'd5; rt = 32'd5; wr_lo = 1'b1; wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; wr_lo = 1'b0;
        cyc = 0; done_cnt = 0;
        while (!done && cyc < 60) begin @(negedge clk); cyc++; end
        check("busy_ign done seen", 64'(done), 64'd1);
        check("busy_ign hi", 64'(hi), 64'd0);
        check("busy_ign lo", 64'(lo), 64'hC);
        repeat (3) @(negedge clk);
        check("busy_ign no relaunch", 64'(busy), 64'd0);

        // MTLO + MTHI, then flush mid-run
        wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h0000_AAAA;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        start = 1'b1; op = 2'b01; rs = 32'd3; rt = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        check("flush no done", 64'(done_cnt), 64'd0);
        check("flush hi", 64'(hi), 64'h0000_AAAA);
        check("flush lo", 64'(lo), 64'h0000_AAAA);

        // Asynchronous reset in the middle of a run
        start = 1'b1; op = 2'b00; rs = 32'd3; rt = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async rst busy", 64'(busy), 64'd0);
        check("async rst hi", 64'(hi), 64'd0);
        check("async rst lo", 64'(lo), 64'd0);
        check("async rst done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post rst stays idle", 64'(busy), 64'd0);
        run_op("post_rst_mult", 2'b00, 32'h8000_0000, 32'h8000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative 32-bit multiply/divide unit in the EX stage of the MIPS pipeline. It executes MULT/MULTU/DIV/DIVU and holds the architectural HI/LO registers, which MTHI/MTLO also write. o_hi and o_lo feed the EX-stage result 4-to-1 mux, whose other inputs are the ALU result and the link address. o_busy drives the hazard unit so that MFHI/MFLO and new mul/div ops stall while the unit is running.

Parameters:
NB_DATA, 32, operand/HI/LO width
NB_OP, 2, operation code width
NB_CNT, 5, iteration counter width (clog2 NB_DATA)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  launch operation (sampled only in IDLE)
i_op  in  NB_OP  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
i_rs  in  NB_DATA  multiplicand / dividend
i_rt  in  NB_DATA  multiplier / divisor
i_wr_hi  in  1  MTHI write enable
i_wr_lo  in  1  MTLO write enable
i_wr_data  in  NB_DATA  MTHI/MTLO data
i_flush  in  1  synchronous abort of in-flight op
o_busy  out  1  operation in progress
o_done  out  1  one-cycle pulse: HI/LO just updated by an op
o_div_by_zero  out  1  qualifies o_done: divisor was zero
o_hi  out  NB_DATA  HI register
o_lo  out  NB_DATA  LO register

Behaviour:
- Reset (async, i_rst_n=0): state IDLE, o_hi=0, o_lo=0, o_busy=0, o_done=0, o_div_by_zero=0, counter=0. Reset mid-operation discards the operation.
- FSM states: IDLE, RUN, FIX.
  - IDLE + i_start at edge E0: latch op, |rs|, |rt|, sign flags (signed ops only); counter<=0; state<=RUN; o_busy<=1.
  - RUN: one iteration per edge (E1..E32). Multiply: shift-add into a 64-bit accumulator. Divide: restoring, 1 quotient bit per edge. When counter==NB_DATA-1, state<=FIX.
  - FIX (edge E33): apply sign correction, write HI/LO, o_done<=1, o_busy<=0, state<=IDLE.
- Latency: 33 cycles from start edge to HI/LO update. o_busy is high for exactly 33 cycles. o_done is high for one cycle.
- Signed rules: product is negated if operand signs differ. Quotient is negated if signs differ. Remainder takes the dividend's sign. Result: MUL gives {HI,LO}=64-bit product; DIV gives LO=quotient, HI=remainder.
- Divide by zero: full 33-cycle latency, HI=i_rs (original), LO=32'hFFFF_FFFF, o_div_by_zero=1 together with o_done.
- DIV 0x8000_0000 / 0xFFFF_FFFF: LO=0x8000_0000, HI=0 (natural wrap, no trap).
- i_start while busy: ignored. Operands are not re-latched.
- i_wr_hi/i_wr_lo: write on the edge when sampled, only while o_busy=0. Ignored while busy.
  - If sampled together with i_start in IDLE, the write happens and the op launches. The later result overwrites.
- i_flush: in RUN or FIX, state<=IDLE, o_busy<=0 next edge; HI/LO unchanged, no o_done. In IDLE it has no effect. Flush has priority over start and over FIX completion in the same cycle.
- o_done and o_div_by_zero are deasserted on every edge that is not a FIX completion.

Decomposition:
- Package mips_pkg:
  - MDU op encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU)
  - NB_DATA
  - MDU state encoding
- Flat module. No sub-module is natural: datapath and FSM share the counter and accumulator registers.

Test Plan:
- MULT rs=0xFFFF_FFFE, rt=0x0000_0003 -> after 33 cycles HI=0xFFFF_FFFF, LO=0xFFFF_FFFA; o_busy high 33 cycles; o_done one-cycle pulse.
- MULTU rs=rt=0xFFFF_FFFF -> HI=0xFFFF_FFFE, LO=0x0000_0001.
- DIV rs=0xFFFF_FFF9 (-7), rt=2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. DIVU rs=7, rt=2 -> LO=3, HI=1.
- DIVU rs=5, rt=0 -> HI=5, LO=0xFFFF_FFFF, o_div_by_zero=1 with o_done. DIV 0x8000_0000 / 0xFFFF_FFFF -> LO=0x8000_0000, HI=0.
- MTHI 0x1234_5678 in IDLE -> o_hi=0x1234_5678 next cycle. Then MULTU 3*4, and at busy cycle 10 a second i_start plus i_wr_lo are both ignored -> HI=0, LO=0xC.
- MULTU 3*4 then i_flush at busy cycle 5 -> o_busy=0 next cycle, HI/LO unchanged, no o_done. Repeat and drop i_rst_n mid-RUN -> all outputs 0 immediately.
